sample_capture: RTL and testbench



---
 rtl/sample_capture_pkg.sv | 20 ++
 rtl/sample_capture_if.sv | 11 +
 rtl/sample_capture_trigger_detect.sv | 39 +++
 rtl/sample_capture.sv | 170 +++++++++++++++++
 tb/tb_sample_capture.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sample_capture_pkg.sv
// rtl/sample_capture_pkg.sv - shared sizes, reset value and capture FSM states for the scope capture path
package osc_pkg;

    localparam int SAMPLES  = 256;
    localparam int SAMPLE_W = 12;
    localparam int IDX_W    = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [IDX_W-1:0]    idx_t;

    localparam sample_t SAMPLE_MID = 12'h800;
    localparam idx_t    IDX_LAST   = 8'hFF;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } capture_state_t;

endpackage

// File: rtl/sample_capture_if.sv
// rtl/sample_capture_if.sv - ADC sample stream into the capture stage
interface sample_capture_if;
    import osc_pkg::*;

    sample_t adc_data;
    logic    adc_valid;

    modport master (output adc_data, output adc_valid);
    modport slave  (input  adc_data, input  adc_valid);

endinterface

// File: rtl/sample_capture_trigger_detect.sv
// rtl/sample_capture_trigger_detect.sv - level/slope trigger on consecutive accepted samples
module trigger_detect
    import osc_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_clear,
    input  logic    i_enable,
    input  logic    i_accept,
    input  sample_t i_sample,
    input  sample_t i_level,
    input  logic    i_slope,
    output logic    o_trig_hit
);

    sample_t r_prev;
    logic    r_have_prev;
    logic    w_rise;
    logic    w_fall;

    assign w_rise = (r_prev < i_level) && (i_sample >= i_level);
    assign w_fall = (r_prev > i_level) && (i_sample <= i_level);

    // The first accepted sample after a clear only seeds r_prev and cannot fire.
    assign o_trig_hit = i_enable && i_accept && r_have_prev && (i_slope ? w_fall : w_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
        end else if (i_clear) begin
            r_have_prev <= 1'b0;
        end else if (i_enable && i_accept) begin
            r_prev      <= i_sample;
            r_have_prev <= 1'b1;
        end
    end

endmodule

// File: rtl/sample_capture.sv
// rtl/sample_capture.sv - decimate, trigger, capture 256 samples, publish on vblank rise (option: SAMPLE_CAPTURE_TRIG_AUTO_EN)
module sample_capture
    import osc_pkg::*;
#(
    parameter int AUTO_TIMEOUT = 4096
)
(
    input  logic             clk,
    input  logic             rst_n,
    sample_capture_if.slave  adc,
    input  sample_t          trig_level,
    input  logic             trig_slope,
    input  logic [3:0]       decim,
    input  logic             vblnk,
    output sample_t          data_display [0:SAMPLES-1],
    output logic             frame_updated,
    output logic             busy,
    output logic             triggered_auto
);

    capture_state_t r_state;
    capture_state_t w_state_nxt;

    logic [3:0] r_decim_cnt;
    logic       r_vblnk_q;
    logic       r_frame_updated;
    logic       r_busy;
    idx_t       r_wr_idx;
    sample_t    r_cap_buf [0:SAMPLES-1];
    sample_t    r_display [0:SAMPLES-1];

    logic w_accept;
    logic w_vblnk_rise;
    logic w_swap;
    logic w_trig_hit;
    logic w_timeout;
    logic w_start;
    logic w_cap_wr;
    logic w_last;

    assign w_accept     = adc.adc_valid && (r_decim_cnt == decim);
    assign w_vblnk_rise = vblnk && !r_vblnk_q;
    // A vblank rise only publishes once the buffer is complete; rises seen while
    // still capturing (including on the final write) are dropped.
    assign w_swap       = (r_state == FULL) && w_vblnk_rise;
    assign w_start      = (r_state == ARMED) && w_accept && (w_trig_hit || w_timeout);
    assign w_cap_wr     = (r_state == CAPTURE) && w_accept;
    assign w_last       = w_cap_wr && (r_wr_idx == IDX_LAST);

    trigger_detect u_trigger_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_swap),
        .i_enable   (r_state == ARMED),
        .i_accept   (w_accept),
        .i_sample   (adc.adc_data),
        .i_level    (trig_level),
        .i_slope    (trig_slope),
        .o_trig_hit (w_trig_hit)
    );

`ifdef SAMPLE_CAPTURE_TRIG_AUTO_EN
    localparam int AW = $clog2(AUTO_TIMEOUT + 1);

    logic [AW-1:0] r_auto_cnt;
    logic          r_auto_pend;
    logic          r_trig_auto;

    assign w_timeout = (r_state == ARMED) && w_accept && (r_auto_cnt == AW'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt  <= '0;
            r_auto_pend <= 1'b0;
            r_trig_auto <= 1'b0;
        end else begin
            if (w_swap) begin
                r_auto_cnt <= '0;
            end else if ((r_state == ARMED) && w_accept) begin
                r_auto_cnt <= r_auto_cnt + AW'(1);
            end
            // A genuine level crossing on the timeout sample still counts as a real trigger.
            if (w_start) begin
                r_auto_pend <= !w_trig_hit;
            end
            if (w_swap) begin
                r_trig_auto <= r_auto_pend;
            end
        end
    end

    assign triggered_auto = r_trig_auto;
`else
    logic w_unused_auto_timeout;

    assign w_timeout             = 1'b0;
    assign triggered_auto        = 1'b0;
    assign w_unused_auto_timeout = (AUTO_TIMEOUT == 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARMED:   if (w_start) w_state_nxt = CAPTURE;
            CAPTURE: if (w_last)  w_state_nxt = FULL;
            FULL:    if (w_swap)  w_state_nxt = ARMED;
            default:              w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARMED;
            r_busy    <= 1'b0;
            r_vblnk_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != ARMED);
            r_vblnk_q <= vblnk;
        end
    end

    // Decimation counter compares against the live decim value on every valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decim_cnt <= '0;
        end else if (w_swap) begin
            r_decim_cnt <= '0;
        end else if (adc.adc_valid) begin
            r_decim_cnt <= w_accept ? 4'd0 : (r_decim_cnt + 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            for (int i = 0; i < SAMPLES; i++) begin
                r_cap_buf[i] <= SAMPLE_MID;
            end
        end else if (w_start) begin
            r_cap_buf[0] <= adc.adc_data;
            r_wr_idx     <= 8'd1;
        end else if (w_cap_wr) begin
            r_cap_buf[r_wr_idx] <= adc.adc_data;
            r_wr_idx            <= r_wr_idx + 8'd1;
        end
    end

    // The whole frame is copied in one edge so the renderer never sees a mixed buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_updated <= 1'b0;
            for (int i = 0; i < SAMPLES; i++) begin
                r_display[i] <= SAMPLE_MID;
            end
        end else begin
            r_frame_updated <= w_swap;
            if (w_swap) begin
                for (int i = 0; i < SAMPLES; i++) begin
                    r_display[i] <= r_cap_buf[i];
                end
            end
        end
    end

    assign data_display  = r_display;
    assign frame_updated = r_frame_updated;
    assign busy          = r_busy;

endmodule

// File: tb/tb_sample_capture.sv
// tb/tb_sample_capture.sv - directed checks of trigger, capture, vblank swap and reset for sample_capture
module tb_sample_capture;
    import osc_pkg::*;

    logic       clk;
    logic       rst_n;
    sample_t    trig_level;
    logic       trig_slope;
    logic [3:0] decim;
    logic       vblnk;
    sample_t    data_display [0:SAMPLES-1];
    logic       frame_updated;
    logic       busy;
    logic       triggered_auto;

    int tests_run    = 0;
    int tests_failed = 0;
    int fu_count     = 0;
    int fu_mark;

    sample_capture_if adc_if ();

    sample_capture #(.AUTO_TIMEOUT(4096)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc            (adc_if),
        .trig_level     (trig_level),
        .trig_slope     (trig_slope),
        .decim          (decim),
        .vblnk          (vblnk),
        .data_display   (data_display),
        .frame_updated  (frame_updated),
        .busy           (busy),
        .triggered_auto (triggered_auto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_updated === 1'b1) fu_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int value);
        @(negedge clk);
        adc_if.adc_data  = sample_t'(value & 12'hFFF);
        adc_if.adc_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            adc_if.adc_valid = 1'b0;
        end
    endtask

    task automatic pulse_vblnk();
        @(negedge clk);
        adc_if.adc_valid = 1'b0;
        vblnk = 1'b1;
        repeat (2) @(negedge clk);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // 900 seeds prev, 1100 crosses level 1000 rising, then base+i fills index i.
    task automatic capture_seq(input int base, input int last_idx, input logic vblnk_on_last);
        push(900);
        push(1100);
        for (int i = 1; i <= last_idx; i++) begin
            push(base + i);
            if (i == 255 && vblnk_on_last) vblnk = 1'b1;
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        adc_if.adc_data  = '0;
        adc_if.adc_valid = 1'b0;
        trig_level       = 12'd1000;
        trig_slope       = 1'b0;
        decim            = 4'd0;
        vblnk            = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_frame_updated", frame_updated, 0);
        check("rst_triggered_auto", triggered_auto, 0);
        check("rst_display0", data_display[0], 12'h800);
        check("rst_display255", data_display[255], 12'h800);
        rst_n = 1'b1;

        // Vblank rises while ARMED never publish.
        fu_mark = fu_count;
        pulse_vblnk();
        pulse_vblnk();
        check("armed_vblnk_no_swap", fu_count - fu_mark, 0);

        // Constant 500 below level 1000: never triggers without the auto timeout.
        for (int k = 0; k < 10000; k++) push(500);
        idle(2);
`ifdef SAMPLE_CAPTURE_TRIG_AUTO_EN
        check("const_busy_auto", busy, 1);
        fu_mark = fu_count;
        pulse_vblnk();
        check("const_swap_auto", fu_count - fu_mark, 1);
        check("const_display0_auto", data_display[0], 500);
        check("const_display255_auto", data_display[255], 500);
        check("const_triggered_auto", triggered_auto, 1);
`else
        check("const_busy", busy, 0);
        check("const_display0", data_display[0], 12'h800);
        check("const_display255", data_display[255], 12'h800);
        fu_mark = fu_count;
        pulse_vblnk();
        check("const_no_swap", fu_count - fu_mark, 0);
`endif

        // Rising ramp step 16 wrapping at 12 bits: trigger on 1008 (after 992).
        for (int k = 0; k < 512; k++) push(k * 16);
        idle(2);
        check("ramp_up_busy_full", busy, 1);
        check("ramp_up_display_frozen", data_display[0] == 12'd1008 ? 0 : 1, 1);
        fu_mark = fu_count;
        pulse_vblnk();
        check("ramp_up_swap_once", fu_count - fu_mark, 1);
        check("ramp_up_busy_after", busy, 0);
        check("ramp_up_d0", data_display[0], 1008);
        check("ramp_up_d1", data_display[1], 1024);
        check("ramp_up_d192", data_display[192], 4080);
        check("ramp_up_d193", data_display[193], 0);
        check("ramp_up_d255", data_display[255], 992);
        check("ramp_up_not_auto", triggered_auto, 0);

        // Falling slope: the rising ramp must not fire, the falling one fires on 992.
        trig_slope = 1'b1;
        for (int k = 0; k < 256; k++) push(k * 16);
        idle(2);
        check("fall_rising_no_trig", busy, 0);
        for (int k = 0; k < 512; k++) push(4080 - 16 * k);
        idle(2);
        fu_mark = fu_count;
        pulse_vblnk();
        check("fall_swap_once", fu_count - fu_mark, 1);
        check("fall_d0", data_display[0], 992);
        check("fall_d1", data_display[1], 976);
        check("fall_d62", data_display[62], 0);
        check("fall_d63", data_display[63], 4080);
        check("fall_d255", data_display[255], 1008);

        // decim=3: value 0 is taken with decim 0, so accepted samples fall on multiples of 4.
        trig_slope = 1'b0;
        trig_level = 12'd100;
        push(0);
        @(negedge clk);
        decim            = 4'd3;
        adc_if.adc_data  = 12'd1;
        adc_if.adc_valid = 1'b1;
        for (int v = 2; v <= 1200; v++) push(v);
        idle(2);
        fu_mark = fu_count;
        pulse_vblnk();
        check("decim_swap_once", fu_count - fu_mark, 1);
        check("decim_d0", data_display[0], 100);
        check("decim_d1", data_display[1], 104);
        check("decim_d255", data_display[255], 1120);

        // Vblank rising together with the index-255 write is not a swap.
        decim      = 4'd0;
        trig_level = 12'd1000;
        fu_mark    = fu_count;
        capture_seq(2000, 255, 1'b1);
        idle(3);
        check("edge_on_last_no_swap", fu_count - fu_mark, 0);
        check("edge_on_last_busy", busy, 1);
        check("edge_on_last_display", data_display[0], 100);
        vblnk = 1'b0;
        idle(2);
        pulse_vblnk();
        check("edge_next_swap", fu_count - fu_mark, 1);
        check("edge_next_d0", data_display[0], 1100);
        check("edge_next_d1", data_display[1], 2001);
        check("edge_next_d255", data_display[255], 2255);

        // Asynchronous reset part way through a capture.
        capture_seq(2500, 110, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        adc_if.adc_valid = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_updated", frame_updated, 0);
        check("mid_rst_display0", data_display[0], 12'h800);
        check("mid_rst_display255", data_display[255], 12'h800);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        fu_mark = fu_count;
        pulse_vblnk();
        check("post_rst_no_swap", fu_count - fu_mark, 0);
        check("post_rst_display0", data_display[0], 12'h800);
        capture_seq(3000, 255, 1'b0);
        idle(2);
        pulse_vblnk();
        check("post_rst_swap", fu_count - fu_mark, 1);
        check("post_rst_d0", data_display[0], 1100);
        check("post_rst_d255", data_display[255], 3255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
